// File: rtl/y86_decode_execute_slice.sv
// Y86-64 F->D and D->E pipeline registers plus the execute stage (ALU, condition codes, cond).
// Latency: f_* to d_* in 1 edge, to e_* in 2 edges; e_valE/e_cond are combinational from E; CC updates 1 edge after E.
// Backpressure: none; both registers load every cycle, and reset flushes both to nop.
// Ports: clk, rst_n (sync, active-low); f_* fetch inputs; d_* D-register outputs (d_rA/d_rB to regfile);
//        d_valA/d_valB regfile read data; e_* E-register outputs; e_valE ALU result; e_cond; ZF/SF/OF CC register.
module y86_decode_execute_slice (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         f_icode,
  input  logic [3:0]         f_ifun,
  input  logic [3:0]         f_rA,
  input  logic [3:0]         f_rB,
  input  logic [63:0]        f_valC,
  input  logic [63:0]        f_valP,
  input  logic               f_hlt,
  input  logic               f_in_inst,
  input  logic               f_in_mem,
  output logic [3:0]         d_icode,
  output logic [3:0]         d_ifun,
  output logic [3:0]         d_rA,
  output logic [3:0]         d_rB,
  output logic [63:0]        d_valC,
  output logic [63:0]        d_valP,
  output logic               d_hlt,
  output logic               d_in_inst,
  output logic               d_in_mem,
  input  logic signed [63:0] d_valA,
  input  logic signed [63:0] d_valB,
  output logic [3:0]         e_icode,
  output logic [3:0]         e_ifun,
  output logic [3:0]         e_rA,
  output logic [3:0]         e_rB,
  output logic [63:0]        e_valA,
  output logic [63:0]        e_valB,
  output logic [63:0]        e_valC,
  output logic [63:0]        e_valP,
  output logic               e_hlt,
  output logic               e_in_mem,
  output logic               e_in_inst,
  output logic signed [63:0] e_valE,
  output logic               e_cond,
  output logic               ZF,
  output logic               SF,
  output logic               OF
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  // D register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_icode   <= I_NOP;
      d_ifun    <= 4'h0;
      d_rA      <= 4'h0;
      d_rB      <= 4'h0;
      d_valC    <= 64'd0;
      d_valP    <= 64'd0;
      d_hlt     <= 1'b0;
      d_in_inst <= 1'b0;
      d_in_mem  <= 1'b0;
    end else begin
      d_icode   <= f_icode;
      d_ifun    <= f_ifun;
      d_rA      <= f_rA;
      d_rB      <= f_rB;
      d_valC    <= f_valC;
      d_valP    <= f_valP;
      d_hlt     <= f_hlt;
      d_in_inst <= f_in_inst;
      d_in_mem  <= f_in_mem;
    end
  end

  // E register; register-file operands are captured at the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_icode   <= I_NOP;
      e_ifun    <= 4'h0;
      e_rA      <= 4'h0;
      e_rB      <= 4'h0;
      e_valA    <= 64'd0;
      e_valB    <= 64'd0;
      e_valC    <= 64'd0;
      e_valP    <= 64'd0;
      e_hlt     <= 1'b0;
      e_in_inst <= 1'b0;
      e_in_mem  <= 1'b0;
    end else begin
      e_icode   <= d_icode;
      e_ifun    <= d_ifun;
      e_rA      <= d_rA;
      e_rB      <= d_rB;
      e_valA    <= d_valA;
      e_valB    <= d_valB;
      e_valC    <= d_valC;
      e_valP    <= d_valP;
      e_hlt     <= d_hlt;
      e_in_inst <= d_in_inst;
      e_in_mem  <= d_in_mem;
    end
  end

  // ALU
  logic [63:0] sum_ba, diff_ba, alu_res;
  logic        op_of;

  assign sum_ba  = e_valB + e_valA;
  assign diff_ba = e_valB - e_valA;

  always_comb begin
    alu_res = 64'd0;
    op_of   = 1'b0;
    case (e_icode)
      I_RRMOV:          alu_res = e_valA;
      I_IRMOV:          alu_res = e_valC;
      I_RMMOV, I_MRMOV: alu_res = e_valB + e_valC;
      I_OPQ: begin
        case (e_ifun)
          4'h0: begin
            alu_res = sum_ba;
            // add overflows when both operands share a sign the result lacks
            op_of   = (e_valA[63] == e_valB[63]) && (sum_ba[63] != e_valB[63]);
          end
          4'h1: begin
            alu_res = diff_ba;
            // B - A overflows when signs differ and the result leaves B's sign
            op_of   = (e_valA[63] != e_valB[63]) && (diff_ba[63] != e_valB[63]);
          end
          4'h2:    alu_res = e_valB & e_valA;
          4'h3:    alu_res = e_valB ^ e_valA;
          default: alu_res = 64'd0;
        endcase
      end
      I_CALL, I_PUSH:   alu_res = e_valB - 64'd8;
      I_RET, I_POP:     alu_res = e_valB + 64'd8;
      default:          alu_res = 64'd0;
    endcase
  end

  assign e_valE = alu_res;

  // CC register: only valid OPq functions update it; status bits do not gate it
  logic cc_wr;
  assign cc_wr = (e_icode == I_OPQ) && (e_ifun <= 4'h3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ZF <= 1'b1;
      SF <= 1'b0;
      OF <= 1'b0;
    end else if (cc_wr) begin
      ZF <= (alu_res == 64'd0);
      SF <= alu_res[63];
      OF <= op_of;
    end
  end

  // Condition from the committed CC (an OPq just ahead has already written it)
  logic cond_raw;
  always_comb begin
    case (e_ifun)
      4'h0:    cond_raw = 1'b1;
      4'h1:    cond_raw = (SF ^ OF) | ZF;
      4'h2:    cond_raw = SF ^ OF;
      4'h3:    cond_raw = ZF;
      4'h4:    cond_raw = ~ZF;
      4'h5:    cond_raw = ~(SF ^ OF);
      4'h6:    cond_raw = ~(SF ^ OF) & ~ZF;
      default: cond_raw = 1'b0;
    endcase
  end

  assign e_cond = ((e_icode == I_RRMOV) || (e_icode == I_JXX)) ? cond_raw : 1'b0;

endmodule

// File: tb/tb_y86_decode_execute_slice.sv
module tb_y86_decode_execute_slice;
  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         f_icode, f_ifun, f_rA, f_rB;
  logic [63:0]        f_valC, f_valP;
  logic               f_hlt, f_in_inst, f_in_mem;
  logic [3:0]         d_icode, d_ifun, d_rA, d_rB;
  logic [63:0]        d_valC, d_valP;
  logic               d_hlt, d_in_inst, d_in_mem;
  logic signed [63:0] d_valA, d_valB;
  logic [3:0]         e_icode, e_ifun, e_rA, e_rB;
  logic [63:0]        e_valA, e_valB, e_valC, e_valP;
  logic               e_hlt, e_in_mem, e_in_inst;
  logic signed [63:0] e_valE;
  logic               e_cond, ZF, SF, OF;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  y86_decode_execute_slice dut (
    .clk(clk), .rst_n(rst_n),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .f_hlt(f_hlt), .f_in_inst(f_in_inst), .f_in_mem(f_in_mem),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
    .d_valC(d_valC), .d_valP(d_valP),
    .d_hlt(d_hlt), .d_in_inst(d_in_inst), .d_in_mem(d_in_mem),
    .d_valA(d_valA), .d_valB(d_valB),
    .e_icode(e_icode), .e_ifun(e_ifun), .e_rA(e_rA), .e_rB(e_rB),
    .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC), .e_valP(e_valP),
    .e_hlt(e_hlt), .e_in_mem(e_in_mem), .e_in_inst(e_in_inst),
    .e_valE(e_valE), .e_cond(e_cond), .ZF(ZF), .SF(SF), .OF(OF)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic f_nop();
    f_icode = 4'h1; f_ifun = 4'h0; f_rA = 4'hF; f_rB = 4'hF;
    f_valC = 64'd0; f_valP = 64'd0;
    f_hlt = 1'b0; f_in_inst = 1'b0; f_in_mem = 1'b0;
  endtask

  // Fetch one instruction followed by nops; on return it sits in E.
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb);
    f_nop();
    f_icode = ic; f_ifun = fn; f_rA = 4'h0; f_rB = 4'h1; f_valC = vc;
    step();
    f_nop();
    d_valA = va; d_valB = vb;
    step();
  endtask

  task automatic test_reset();
    f_nop();
    f_icode = 4'h6; f_valC = 64'hDEAD; f_hlt = 1'b1;
    d_valA = 64'd7; d_valB = 64'd9;
    rst_n = 1'b0;
    step();
    step();
    total++; if (d_icode !== 4'h1) begin bad++; $display("FAIL reset_d_icode got=%h exp=1", d_icode); end
    total++; if (e_icode !== 4'h1) begin bad++; $display("FAIL reset_e_icode got=%h exp=1", e_icode); end
    total++; if (d_valC !== 64'd0 || d_hlt !== 1'b0) begin bad++; $display("FAIL reset_d_fields valC=%h hlt=%b exp=0", d_valC, d_hlt); end
    total++; if (e_valA !== 64'd0 || e_valB !== 64'd0) begin bad++; $display("FAIL reset_e_vals A=%h B=%h exp=0", e_valA, e_valB); end
    total++; if (e_valE !== 64'd0) begin bad++; $display("FAIL reset_valE got=%h exp=0", e_valE); end
    total++; if ({ZF, SF, OF} !== 3'b100) begin bad++; $display("FAIL reset_cc got=%b exp=100", {ZF, SF, OF}); end
    f_nop();
    d_valA = 64'd0; d_valB = 64'd0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_propagation();
    f_nop();
    f_icode = 4'h3; f_valC = 64'h1234; f_rB = 4'h2; f_valP = 64'h40; f_in_mem = 1'b1;
    step();
    total++; if (d_valC !== 64'h1234) begin bad++; $display("FAIL prop_d_valC got=%h exp=1234", d_valC); end
    total++; if (d_icode !== 4'h3 || d_rB !== 4'h2) begin bad++; $display("FAIL prop_d_icode_rB got=%h/%h exp=3/2", d_icode, d_rB); end
    total++; if (e_icode !== 4'h1) begin bad++; $display("FAIL prop_e_not_yet got=%h exp=1", e_icode); end
    f_nop();
    step();
    total++; if (e_icode !== 4'h3) begin bad++; $display("FAIL prop_e_icode got=%h exp=3", e_icode); end
    total++; if (e_valE !== 64'h1234) begin bad++; $display("FAIL prop_e_valE got=%h exp=1234", e_valE); end
    total++; if (e_rB !== 4'h2 || e_valP !== 64'h40 || e_in_mem !== 1'b1) begin bad++; $display("FAIL prop_e_fields rB=%h valP=%h mem=%b exp=2/40/1", e_rB, e_valP, e_in_mem); end
  endtask

  task automatic test_add_overflow();
    issue(4'h6, 4'h0, 64'd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
    total++; if (e_valE !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL add_valE got=%h exp=8000000000000000", e_valE); end
    step();
    total++; if ({ZF, SF, OF} !== 3'b011) begin bad++; $display("FAIL add_cc got=%b exp=011", {ZF, SF, OF}); end
    // SF=1, OF=1, ZF=0: l -> 0, ge -> 1, g -> 1
    issue(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    total++; if (e_cond !== 1'b0) begin bad++; $display("FAIL cond_l got=%b exp=0", e_cond); end
    issue(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    total++; if (e_cond !== 1'b1) begin bad++; $display("FAIL cond_ge got=%b exp=1", e_cond); end
    issue(4'h2, 4'h6, 64'd0, 64'd0, 64'd0);
    total++; if (e_cond !== 1'b1) begin bad++; $display("FAIL cond_g got=%b exp=1", e_cond); end
  endtask

  task automatic test_stack();
    issue(4'h8, 4'h0, 64'd0, 64'd0, 64'h100);
    total++; if (e_valE !== 64'hF8) begin bad++; $display("FAIL call_valE got=%h exp=f8", e_valE); end
    issue(4'hB, 4'h0, 64'd0, 64'd0, 64'h100);
    total++; if (e_valE !== 64'h108) begin bad++; $display("FAIL popq_valE got=%h exp=108", e_valE); end
    issue(4'hA, 4'h0, 64'd0, 64'd5, 64'h100);
    total++; if (e_valE !== 64'hF8) begin bad++; $display("FAIL pushq_valE got=%h exp=f8", e_valE); end
    issue(4'h9, 4'h0, 64'd0, 64'd0, 64'h100);
    total++; if (e_valE !== 64'h108) begin bad++; $display("FAIL ret_valE got=%h exp=108", e_valE); end
    issue(4'h4, 4'h0, 64'h20, 64'd3, 64'h10);
    total++; if (e_valE !== 64'h30) begin bad++; $display("FAIL rmmovq_valE got=%h exp=30", e_valE); end
    issue(4'h0, 4'h0, 64'h77, 64'h55, 64'h66);
    total++; if (e_valE !== 64'd0) begin bad++; $display("FAIL halt_valE got=%h exp=0", e_valE); end
    issue(4'h5, 4'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'h10);
    total++; if (e_valE !== 64'h8) begin bad++; $display("FAIL mrmovq_valE got=%h exp=8", e_valE); end
    step();
    total++; if ({ZF, SF, OF} !== 3'b011) begin bad++; $display("FAIL mrmovq_cc_hold got=%b exp=011", {ZF, SF, OF}); end
  endtask

  task automatic test_logic();
    issue(4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000);
    total++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL subov_valE got=%h exp=7fffffffffffffff", e_valE); end
    step();
    total++; if ({ZF, SF, OF} !== 3'b001) begin bad++; $display("FAIL subov_cc got=%b exp=001", {ZF, SF, OF}); end
    issue(4'h6, 4'h2, 64'd0, 64'h3C, 64'hF0);
    total++; if (e_valE !== 64'h30) begin bad++; $display("FAIL and_valE got=%h exp=30", e_valE); end
    step();
    total++; if ({ZF, SF, OF} !== 3'b000) begin bad++; $display("FAIL and_cc got=%b exp=000", {ZF, SF, OF}); end
    issue(4'h6, 4'h3, 64'd0, 64'h3C, 64'h8000_0000_0000_00F0);
    total++; if (e_valE !== 64'h8000_0000_0000_00CC) begin bad++; $display("FAIL xor_valE got=%h exp=80000000000000cc", e_valE); end
    step();
    total++; if ({ZF, SF, OF} !== 3'b010) begin bad++; $display("FAIL xor_cc got=%b exp=010", {ZF, SF, OF}); end
    issue(4'h6, 4'h4, 64'd0, 64'd0, 64'd0);
    total++; if (e_valE !== 64'd0) begin bad++; $display("FAIL badfun_valE got=%h exp=0", e_valE); end
    step();
    total++; if ({ZF, SF, OF} !== 3'b010) begin bad++; $display("FAIL badfun_cc_hold got=%b exp=010", {ZF, SF, OF}); end
  endtask

  task automatic test_sub_zero();
    issue(4'h6, 4'h1, 64'd0, 64'd5, 64'd5);
    total++; if (e_valE !== 64'd0) begin bad++; $display("FAIL sub0_valE got=%h exp=0", e_valE); end
    step();
    total++; if ({ZF, SF, OF} !== 3'b100) begin bad++; $display("FAIL sub0_cc got=%b exp=100", {ZF, SF, OF}); end
  endtask

  task automatic test_conditions();
    issue(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    total++; if (e_cond !== 1'b1) begin bad++; $display("FAIL cond_e got=%b exp=1", e_cond); end
    issue(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
    total++; if (e_cond !== 1'b0) begin bad++; $display("FAIL cond_ne got=%b exp=0", e_cond); end
    issue(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
    total++; if (e_cond !== 1'b1) begin bad++; $display("FAIL cond_le got=%b exp=1", e_cond); end
    issue(4'h2, 4'h0, 64'd0, 64'h99, 64'd0);
    total++; if (e_cond !== 1'b1) begin bad++; $display("FAIL cmov_uncond got=%b exp=1", e_cond); end
    total++; if (e_valE !== 64'h99) begin bad++; $display("FAIL cmov_valE got=%h exp=99", e_valE); end
    issue(4'h4, 4'h0, 64'd0, 64'd0, 64'd0);
    total++; if (e_cond !== 1'b0) begin bad++; $display("FAIL cond_rmmovq got=%b exp=0", e_cond); end
    issue(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
    total++; if (e_cond !== 1'b0) begin bad++; $display("FAIL cond_fun7 got=%b exp=0", e_cond); end
  endtask

  // OPq directly followed by jne: the jump must see the OPq's flags.
  task automatic test_back_to_back();
    f_nop();
    f_icode = 4'h6; f_ifun = 4'h0;
    step();
    d_valA = 64'd1; d_valB = 64'd1;
    f_nop();
    f_icode = 4'h7; f_ifun = 4'h4;
    step();
    total++; if (e_valE !== 64'd2) begin bad++; $display("FAIL b2b_valE got=%h exp=2", e_valE); end
    f_nop();
    step();
    total++; if (e_icode !== 4'h7 || e_cond !== 1'b1) begin bad++; $display("FAIL b2b_cond icode=%h cond=%b exp=7/1", e_icode, e_cond); end
    total++; if (ZF !== 1'b0) begin bad++; $display("FAIL b2b_zf got=%b exp=0", ZF); end
  endtask

  // Reset while an OPq sits in E: flush wins over the CC write.
  task automatic test_reset_midstream();
    f_nop();
    f_icode = 4'h6; f_ifun = 4'h0;
    step();
    d_valA = 64'h4000_0000_0000_0000; d_valB = 64'h4000_0000_0000_0000;
    f_nop();
    f_icode = 4'h3; f_valC = 64'h55;
    step();
    total++; if (e_icode !== 4'h6 || d_icode !== 4'h3) begin bad++; $display("FAIL mid_pre e=%h d=%h exp=6/3", e_icode, d_icode); end
    rst_n = 1'b0;
    step();
    total++; if (d_icode !== 4'h1 || e_icode !== 4'h1) begin bad++; $display("FAIL mid_flush d=%h e=%h exp=1/1", d_icode, e_icode); end
    total++; if ({ZF, SF, OF} !== 3'b100) begin bad++; $display("FAIL mid_cc got=%b exp=100", {ZF, SF, OF}); end
    rst_n = 1'b1;
    f_nop();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    f_nop();
    d_valA = 64'd0;
    d_valB = 64'd0;
    test_reset();
    test_propagation();
    test_add_overflow();
    test_stack();
    test_logic();
    test_sub_zero();
    test_conditions();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
